sec_counter: RTL and testbench

SEC_COUNTER -- requirements
Module: sec_counter

---
 rtl/sec_counter.sv | 94 +++++++++
 tb/tb_sec_counter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sec_counter.sv
// MM:SS stopwatch counter: a DIV-cycle prescaler generates one-second steps that
// advance a four-digit BCD time value, controlled by a 2-bit run/pause/clear code.
module sec_counter #(
  parameter int DIV = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] en,
  output logic [3:0] sec_lo,
  output logic [3:0] sec_hi,
  output logic [3:0] min_lo,
  output logic [3:0] min_hi,
  output logic       tick,
  output logic       wrap,
  output logic       running
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] TERMINAL = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } mode_t;

  mode_t         mode;
  logic [PW-1:0] prescale;

  // Every branch acts on the code sampled at this edge, so an en change that lands
  // on the prescaler terminal count is resolved entirely by the new code.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode     <= IDLE;
      prescale <= '0;
      sec_lo   <= 4'd0;
      sec_hi   <= 4'd0;
      min_lo   <= 4'd0;
      min_hi   <= 4'd0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
      case (en)
        2'b01: begin
          mode <= RUN;
          if (prescale >= TERMINAL) begin
            prescale <= '0;
            tick     <= 1'b1;
            // Range checks use >= so a corrupted digit still collapses back into BCD.
            if (sec_lo >= 4'd9) begin
              sec_lo <= 4'd0;
              if (sec_hi >= 4'd5) begin
                sec_hi <= 4'd0;
                if (min_lo >= 4'd9) begin
                  min_lo <= 4'd0;
                  if (min_hi >= 4'd5) begin
                    min_hi <= 4'd0;
                    wrap   <= 1'b1;
                  end else begin
                    min_hi <= min_hi + 4'd1;
                  end
                end else begin
                  min_lo <= min_lo + 4'd1;
                end
              end else begin
                sec_hi <= sec_hi + 4'd1;
              end
            end else begin
              sec_lo <= sec_lo + 4'd1;
            end
          end else begin
            prescale <= prescale + PW'(1);
          end
        end
        2'b10: begin
          mode <= PAUSE;
        end
        default: begin
          mode     <= IDLE;
          prescale <= '0;
          sec_lo   <= 4'd0;
          sec_hi   <= 4'd0;
          min_lo   <= 4'd0;
          min_hi   <= 4'd0;
        end
      endcase
    end
  end

  assign running = (mode == RUN);

endmodule

// File: tb/tb_sec_counter.sv
// Directed-vector bench for sec_counter with DIV=4 (one second every four clocks).
module tb_sec_counter;

  localparam int DIV = 4;

  logic       clk;
  logic       reset;
  logic [1:0] en;
  logic [3:0] sec_lo, sec_hi, min_lo, min_hi;
  logic       tick, wrap, running;

  int total = 0;
  int bad   = 0;

  sec_counter #(.DIV(DIV)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .sec_lo  (sec_lo),
    .sec_hi  (sec_hi),
    .min_lo  (min_lo),
    .min_hi  (min_hi),
    .tick    (tick),
    .wrap    (wrap),
    .running (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on falling edges; outputs are observed on falling edges too.
  task automatic do_clear();
    en = 2'b00;
    @(negedge clk);
  endtask

  task automatic run_edges(input int n);
    en = 2'b01;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    en    = 2'b01;
    #3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      en = (i % 2 == 0) ? 2'b00 : 2'b01;
      total++;
      if ({min_hi, min_lo, sec_hi, sec_lo, tick, wrap, running} !== 19'd0) begin
        bad++;
        $display("[TB] FAIL reset_hold: got %h%h:%h%h t=%b w=%b r=%b, want 00:00 0 0 0",
                 min_hi, min_lo, sec_hi, sec_lo, tick, wrap, running);
      end
    end
    en    = 2'b01;
    reset = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      total++;
      if (tick !== (e == 4)) begin
        bad++;
        $display("[TB] FAIL first_tick edge %0d: tick=%b want %b", e, tick, (e == 4));
      end
      total++;
      if (running !== 1'b1) begin
        bad++;
        $display("[TB] FAIL running_after_release edge %0d: got %b want 1", e, running);
      end
    end
    total++;
    if (sec_lo !== 4'd1) begin
      bad++;
      $display("[TB] FAIL first_tick_value: sec_lo=%0d want 1", sec_lo);
    end
  endtask

  task automatic test_carry();
    int ticks;
    do_clear();
    ticks = 0;
    en = 2'b01;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tick === 1'b1) ticks++;
      total++;
      if (tick !== (i % 4 == 3)) begin
        bad++;
        $display("[TB] FAIL tick_period cycle %0d: tick=%b want %b", i, tick, (i % 4 == 3));
      end
    end
    total++;
    if (ticks != 10) begin
      bad++;
      $display("[TB] FAIL tick_count: got %0d want 10", ticks);
    end
    total++;
    if ({min_hi, min_lo, sec_hi, sec_lo} !== 16'h0010) begin
      bad++;
      $display("[TB] FAIL sec_carry: got %h%h:%h%h want 00:10", min_hi, min_lo, sec_hi, sec_lo);
    end
  endtask

  task automatic test_pause();
    int pause_ticks;
    do_clear();
    run_edges(2);
    en = 2'b10;
    pause_ticks = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tick !== 1'b0) pause_ticks++;
    end
    total++;
    if (pause_ticks != 0) begin
      bad++;
      $display("[TB] FAIL pause_tick: got %0d ticks want 0", pause_ticks);
    end
    total++;
    if (running !== 1'b0 || sec_lo !== 4'd0) begin
      bad++;
      $display("[TB] FAIL pause_state: running=%b sec_lo=%0d want 0 0", running, sec_lo);
    end
    en = 2'b01;
    @(negedge clk);
    total++;
    if (tick !== 1'b0) begin
      bad++;
      $display("[TB] FAIL resume_early: tick=%b want 0", tick);
    end
    @(negedge clk);
    total++;
    if (tick !== 1'b1 || sec_lo !== 4'd1) begin
      bad++;
      $display("[TB] FAIL resume_tick: tick=%b sec_lo=%0d want 1 1", tick, sec_lo);
    end
  endtask

  task automatic test_wrap();
    int early_wraps;
    do_clear();
    en = 2'b01;
    early_wraps = 0;
    for (int i = 0; i < 3599 * DIV; i++) begin
      @(negedge clk);
      if (wrap !== 1'b0) early_wraps++;
    end
    total++;
    if (early_wraps != 0) begin
      bad++;
      $display("[TB] FAIL early_wrap: got %0d pulses want 0", early_wraps);
    end
    total++;
    if ({min_hi, min_lo, sec_hi, sec_lo} !== 16'h5959) begin
      bad++;
      $display("[TB] FAIL reach_5959: got %h%h:%h%h want 59:59", min_hi, min_lo, sec_hi, sec_lo);
    end
    repeat (DIV) @(negedge clk);
    total++;
    if ({min_hi, min_lo, sec_hi, sec_lo, tick, wrap} !== 18'b11) begin
      bad++;
      $display("[TB] FAIL rollover: got %h%h:%h%h t=%b w=%b want 00:00 1 1",
               min_hi, min_lo, sec_hi, sec_lo, tick, wrap);
    end
    @(negedge clk);
    total++;
    if (tick !== 1'b0 || wrap !== 1'b0 || running !== 1'b1) begin
      bad++;
      $display("[TB] FAIL wrap_width: t=%b w=%b r=%b want 0 0 1", tick, wrap, running);
    end
  endtask

  task automatic test_idle_clear();
    logic [1:0] codes [2];
    codes[0] = 2'b00;
    codes[1] = 2'b11;
    for (int c = 0; c < 2; c++) begin
      do_clear();
      run_edges(37 * DIV + 2);
      total++;
      if ({min_hi, min_lo, sec_hi, sec_lo} !== 16'h0037) begin
        bad++;
        $display("[TB] FAIL reach_0037: got %h%h:%h%h want 00:37", min_hi, min_lo, sec_hi, sec_lo);
      end
      en = codes[c];
      @(negedge clk);
      total++;
      if ({min_hi, min_lo, sec_hi, sec_lo, running} !== 17'd0) begin
        bad++;
        $display("[TB] FAIL idle_clear en=%b: got %h%h:%h%h r=%b want 00:00 0",
                 codes[c], min_hi, min_lo, sec_hi, sec_lo, running);
      end
      run_edges(DIV - 1);
      total++;
      if (tick !== 1'b0) begin
        bad++;
        $display("[TB] FAIL idle_prescale_kept en=%b: tick=%b want 0", codes[c], tick);
      end
      @(negedge clk);
      total++;
      if (tick !== 1'b1 || sec_lo !== 4'd1) begin
        bad++;
        $display("[TB] FAIL idle_restart en=%b: tick=%b sec_lo=%0d want 1 1", codes[c], tick, sec_lo);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_clear();
    run_edges(3);
    en = 2'b10;
    @(negedge clk);
    total++;
    if (tick !== 1'b0 || sec_lo !== 4'd0) begin
      bad++;
      $display("[TB] FAIL pause_at_terminal: tick=%b sec_lo=%0d want 0 0", tick, sec_lo);
    end
    en = 2'b01;
    @(negedge clk);
    total++;
    if (tick !== 1'b1 || sec_lo !== 4'd1) begin
      bad++;
      $display("[TB] FAIL run_at_terminal: tick=%b sec_lo=%0d want 1 1", tick, sec_lo);
    end
    run_edges(3);
    en = 2'b00;
    @(negedge clk);
    total++;
    if (tick !== 1'b0 || sec_lo !== 4'd0) begin
      bad++;
      $display("[TB] FAIL clear_at_terminal: tick=%b sec_lo=%0d want 0 0", tick, sec_lo);
    end
  endtask

  task automatic test_async_reset();
    do_clear();
    run_edges(DIV + 2);
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({min_hi, min_lo, sec_hi, sec_lo, tick, wrap, running} !== 19'd0) begin
      bad++;
      $display("[TB] FAIL async_reset: got %h%h:%h%h t=%b w=%b r=%b want all 0",
               min_hi, min_lo, sec_hi, sec_lo, tick, wrap, running);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int e = 1; e <= DIV; e++) begin
      @(negedge clk);
      total++;
      if (tick !== (e == DIV)) begin
        bad++;
        $display("[TB] FAIL reset_restart edge %0d: tick=%b want %b", e, tick, (e == DIV));
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    en    = 2'b00;
    test_reset();
    test_carry();
    test_pause();
    test_wrap();
    test_idle_clear();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
